// File: rtl/axi_slave_ram_if.sv
// AXI4 bus bundle for axi_slave_ram: AW/W/B/AR/R channels with master and slave views.
// Clock and reset stay outside the bundle as plain module ports.
interface axi_slave_ram_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [31:0]           awaddr;
  logic [ID_WIDTH-1:0]   awid;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [ID_WIDTH-1:0]   wid;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [31:0]           araddr;
  logic [ID_WIDTH-1:0]   arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awid, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  araddr, arid, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awid, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output araddr, arid, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by a byte-lane RAM; independent write and read FSMs, one burst each,
// FIXED/INCR bursts of 1-256 beats, SLVERR on beats that fall outside the RAM.
module axi_slave_ram #(
  parameter int S_AXI_ID_WIDTH   = 4,
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int S_AXI_STRB_WIDTH = S_AXI_DATA_WIDTH / 8,
  parameter int MEM_DEPTH        = 1024
) (
  input logic            s_axi_aclk,
  input logic            s_axi_aresetn,
  axi_slave_ram_if.slave s_axi
);
  localparam int          ADDR_LSB    = $clog2(S_AXI_STRB_WIDTH);
  localparam int          IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [31:0] MEM_BYTES   = 32'(MEM_DEPTH * S_AXI_STRB_WIDTH);
  localparam logic [31:0] BEAT_BYTES  = 32'(S_AXI_STRB_WIDTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // WRAP and reserved encodings fall through to the INCR path.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic fixed);
    return fixed ? addr : addr + BEAT_BYTES;
  endfunction

  // Write channel state
  w_state_t                    w_state_reg;
  logic                        awready_reg;
  logic                        wready_reg;
  logic                        bvalid_reg;
  logic [1:0]                  bresp_reg;
  logic [S_AXI_ID_WIDTH-1:0]   bid_reg;
  logic [S_AXI_ID_WIDTH-1:0]   w_id_reg;
  logic [31:0]                 w_addr_reg;
  logic [7:0]                  w_len_reg;
  logic [7:0]                  w_cnt_reg;
  logic                        w_fixed_reg;
  logic                        w_err_reg;

  // Read channel state
  r_state_t                    r_state_reg;
  logic                        arready_reg;
  logic                        rvalid_reg;
  logic                        rlast_reg;
  logic [1:0]                  rresp_reg;
  logic [S_AXI_ID_WIDTH-1:0]   rid_reg;
  logic [S_AXI_DATA_WIDTH-1:0] rdata_reg;
  logic [31:0]                 r_addr_reg;
  logic [7:0]                  r_len_reg;
  logic [7:0]                  r_cnt_reg;
  logic                        r_fixed_reg;

  logic                        w_fire;
  logic                        w_oor;
  logic                        w_final;
  logic                        w_beat_err;
  logic                        ram_we;
  logic [IDX_W-1:0]            w_idx;
  logic [31:0]                 r_rd_addr;
  logic                        r_oor;
  logic [IDX_W-1:0]            r_idx;
  logic [S_AXI_DATA_WIDTH-1:0] rd_word;
  logic                        unused_sigs;

  assign w_fire     = (w_state_reg == W_DATA) && s_axi.wvalid && wready_reg;
  assign w_oor      = (w_addr_reg >= MEM_BYTES);
  assign w_final    = (w_cnt_reg == w_len_reg);
  // The beat counter decides where the burst ends; wlast only contributes to the error.
  assign w_beat_err = w_oor || (s_axi.wlast != w_final);
  assign ram_we     = w_fire && !w_oor;
  assign w_idx      = w_addr_reg[ADDR_LSB +: IDX_W];

  // The first beat reads straight from the AR address so it is ready one cycle later.
  assign r_rd_addr  = (r_state_reg == R_IDLE) ? s_axi.araddr : r_addr_reg;
  assign r_oor      = (r_rd_addr >= MEM_BYTES);
  assign r_idx      = r_rd_addr[ADDR_LSB +: IDX_W];

  assign unused_sigs = ^{s_axi.wid, s_axi.awsize, s_axi.arsize};

  genvar gi;
  generate
    for (gi = 0; gi < S_AXI_STRB_WIDTH; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_DEPTH];

      always_ff @(posedge s_axi_aclk) begin
        if (ram_we && s_axi.wstrb[gi]) begin
          lane_mem[w_idx] <= s_axi.wdata[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_mem[r_idx];
    end
  endgenerate

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_reg <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      bid_reg     <= '0;
      w_id_reg    <= '0;
      w_addr_reg  <= '0;
      w_len_reg   <= '0;
      w_cnt_reg   <= '0;
      w_fixed_reg <= 1'b0;
      w_err_reg   <= 1'b0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (s_axi.awvalid && awready_reg) begin
            w_id_reg    <= s_axi.awid;
            w_addr_reg  <= s_axi.awaddr;
            w_len_reg   <= s_axi.awlen;
            w_fixed_reg <= (s_axi.awburst == BURST_FIXED);
            w_cnt_reg   <= '0;
            w_err_reg   <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b1;
            w_state_reg <= W_DATA;
          end else begin
            awready_reg <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_final) begin
              wready_reg  <= 1'b0;
              bvalid_reg  <= 1'b1;
              bid_reg     <= w_id_reg;
              bresp_reg   <= (w_err_reg || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state_reg <= W_RESP;
            end else begin
              w_cnt_reg  <= w_cnt_reg + 8'd1;
              w_err_reg  <= w_err_reg || w_beat_err;
              w_addr_reg <= next_addr(w_addr_reg, w_fixed_reg);
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rid_reg     <= '0;
      rdata_reg   <= '0;
      r_addr_reg  <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      r_fixed_reg <= 1'b0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (s_axi.arvalid && arready_reg) begin
            arready_reg <= 1'b0;
            rid_reg     <= s_axi.arid;
            r_len_reg   <= s_axi.arlen;
            r_fixed_reg <= (s_axi.arburst == BURST_FIXED);
            r_cnt_reg   <= '0;
            rvalid_reg  <= 1'b1;
            rlast_reg   <= (s_axi.arlen == 8'd0);
            rdata_reg   <= r_oor ? '0 : rd_word;
            rresp_reg   <= r_oor ? RESP_SLVERR : RESP_OKAY;
            r_addr_reg  <= next_addr(s_axi.araddr, s_axi.arburst == BURST_FIXED);
            r_state_reg <= R_DATA;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_DATA: begin
          if (rvalid_reg && s_axi.rready) begin
            if (rlast_reg) begin
              rvalid_reg  <= 1'b0;
              rlast_reg   <= 1'b0;
              arready_reg <= 1'b1;
              r_state_reg <= R_IDLE;
            end else begin
              rdata_reg  <= r_oor ? '0 : rd_word;
              rresp_reg  <= r_oor ? RESP_SLVERR : RESP_OKAY;
              rlast_reg  <= ((r_cnt_reg + 8'd1) == r_len_reg);
              r_cnt_reg  <= r_cnt_reg + 8'd1;
              r_addr_reg <= next_addr(r_addr_reg, r_fixed_reg);
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awready_reg;
  assign s_axi.wready  = wready_reg;
  assign s_axi.bvalid  = bvalid_reg;
  assign s_axi.bresp   = bresp_reg;
  assign s_axi.bid     = bid_reg;
  assign s_axi.arready = arready_reg;
  assign s_axi.rvalid  = rvalid_reg;
  assign s_axi.rlast   = rlast_reg;
  assign s_axi.rresp   = rresp_reg;
  assign s_axi.rid     = rid_reg;
  assign s_axi.rdata   = rdata_reg;
endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram: bursts, strobes, FIXED/INCR, out-of-range, backpressure, reset.
module tb_axi_slave_ram;
  localparam int IDW   = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int TMO   = 50;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_slave_ram_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) bus ();

  axi_slave_ram #(
    .S_AXI_ID_WIDTH  (IDW),
    .S_AXI_DATA_WIDTH(DW),
    .MEM_DEPTH       (DEPTH)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .s_axi        (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] wr_data  [256];
  logic [31:0] exp_data [256];
  logic [1:0]  exp_resp [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    n_checks++;
    if (obs === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expected);
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [IDW-1:0] id,
                         input logic [7:0] len, input logic [1:0] burst);
    int t;
    @(negedge clk);
    bus.awaddr = addr; bus.awid = id; bus.awlen = len; bus.awsize = 3'd2;
    bus.awburst = burst; bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < TMO) begin @(negedge clk); t++; end
    if (!bus.awready) check("aw_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("aw_to_wready", 32'(bus.wready), 32'd1);
  endtask

  // last_idx selects which beat carries wlast (-1: none)
  task automatic w_send(input int n, input logic [3:0] strb, input int last_idx);
    int t;
    for (int i = 0; i < n; i++) begin
      bus.wdata = wr_data[i]; bus.wstrb = strb; bus.wlast = (i == last_idx);
      bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < TMO) begin @(negedge clk); t++; end
      if (!bus.wready) check("w_timeout", 32'd0, 32'd1);
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic b_recv(input logic [1:0] resp, input logic [IDW-1:0] id);
    int t;
    t = 0;
    while (!bus.bvalid && t < TMO) begin @(negedge clk); t++; end
    check("bvalid", 32'(bus.bvalid), 32'd1);
    check("bresp", 32'(bus.bresp), 32'(resp));
    check("bid", 32'(bus.bid), 32'(id));
    @(negedge clk);
    check("b_clear", 32'(bus.bvalid), 32'd0);
    check("aw_rearm", 32'(bus.awready), 32'd1);
    $display("B  id=%0h resp=%0b", id, resp);
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [IDW-1:0] id,
                         input logic [7:0] len, input logic [1:0] burst);
    int t;
    @(negedge clk);
    bus.araddr = addr; bus.arid = id; bus.arlen = len; bus.arsize = 3'd2;
    bus.arburst = burst; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < TMO) begin @(negedge clk); t++; end
    if (!bus.arready) check("ar_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("ar_to_rvalid", 32'(bus.rvalid), 32'd1);
  endtask

  task automatic r_recv(input int n, input logic [IDW-1:0] id, input bit stall);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!bus.rvalid && t < TMO) begin @(negedge clk); t++; end
      if (!bus.rvalid) check("r_timeout", 32'd0, 32'd1);
      check("rdata", bus.rdata, exp_data[i]);
      check("rresp", 32'(bus.rresp), 32'(exp_resp[i]));
      check("rlast", 32'(bus.rlast), 32'(i == n - 1));
      check("rid", 32'(bus.rid), 32'(id));
      $display("R  id=%0h beat=%0d data=%08h resp=%0b", id, i, bus.rdata, bus.rresp);
      if (stall) begin
        bus.rready = 1'b0;
        @(negedge clk);
        check("r_stall_valid", 32'(bus.rvalid), 32'd1);
        check("r_stall_data", bus.rdata, exp_data[i]);
        bus.rready = 1'b1;
      end
      @(negedge clk);
    end
    check("r_done", 32'(bus.rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.wvalid = 1'b0; bus.bready = 1'b1; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
    bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

    // Reset values, then readies rise one clock after release
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_bresp", 32'(bus.bresp), 32'd0);
    check("rst_bid", 32'(bus.bid), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rlast", 32'(bus.rlast), 32'd0);
    check("rst_rresp", 32'(bus.rresp), 32'd0);
    check("rst_rid", 32'(bus.rid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
    check("pre_clk_awready", 32'(bus.awready), 32'd0);
    @(negedge clk);
    check("post_rst_awready", 32'(bus.awready), 32'd1);
    check("post_rst_arready", 32'(bus.arready), 32'd1);

    // 4-beat INCR write and read-back
    wr_data[0] = 32'h11111111; wr_data[1] = 32'h22222222;
    wr_data[2] = 32'h33333333; wr_data[3] = 32'h44444444;
    aw_send(32'h0, 4'h3, 8'd3, INCR); w_send(4, 4'hF, 3); b_recv(2'b00, 4'h3);
    for (int i = 0; i < 4; i++) begin exp_data[i] = wr_data[i]; exp_resp[i] = 2'b00; end
    ar_send(32'h0, 4'h5, 8'd3, INCR); r_recv(4, 4'h5, 1'b0);

    // Byte strobes 0101 over 0x33333333
    wr_data[0] = 32'hAABBCCDD;
    aw_send(32'h8, 4'h1, 8'd0, INCR); w_send(1, 4'b0101, 0); b_recv(2'b00, 4'h1);
    exp_data[0] = 32'h33BB33DD; exp_resp[0] = 2'b00;
    ar_send(32'h8, 4'h2, 8'd0, INCR); r_recv(1, 4'h2, 1'b0);

    // FIXED write lands all beats on one word; FIXED read repeats it
    wr_data[0] = 32'd1; wr_data[1] = 32'd2; wr_data[2] = 32'd3;
    aw_send(32'h10, 4'h6, 8'd2, FIXED); w_send(3, 4'hF, 2); b_recv(2'b00, 4'h6);
    exp_data[0] = 32'd3; exp_resp[0] = 2'b00;
    ar_send(32'h10, 4'h7, 8'd0, INCR); r_recv(1, 4'h7, 1'b0);
    for (int i = 0; i < 4; i++) begin exp_data[i] = 32'd3; exp_resp[i] = 2'b00; end
    ar_send(32'h10, 4'h7, 8'd3, FIXED); r_recv(4, 4'h7, 1'b0);

    // Out of range: write at 0x1000 aliases word 0 and must not touch it
    wr_data[0] = 32'h5A5A5A5A;
    aw_send(32'hFFC, 4'h8, 8'd0, INCR); w_send(1, 4'hF, 0); b_recv(2'b00, 4'h8);
    wr_data[0] = 32'hDEADBEEF;
    aw_send(32'h1000, 4'h9, 8'd0, INCR); w_send(1, 4'hF, 0); b_recv(2'b10, 4'h9);
    exp_data[0] = 32'h11111111; exp_resp[0] = 2'b00;
    ar_send(32'h0, 4'h9, 8'd0, INCR); r_recv(1, 4'h9, 1'b0);
    exp_data[0] = 32'h5A5A5A5A; exp_resp[0] = 2'b00;
    exp_data[1] = 32'h0;        exp_resp[1] = 2'b10;
    ar_send(32'hFFC, 4'h4, 8'd1, INCR); r_recv(2, 4'h4, 1'b0);

    // 16-beat read with rready stalling every beat
    for (int i = 0; i < 16; i++) begin
      wr_data[i] = 32'h10000000 + 32'(i) * 32'h0101;
      exp_data[i] = wr_data[i]; exp_resp[i] = 2'b00;
    end
    aw_send(32'h100, 4'h2, 8'd15, INCR); w_send(16, 4'hF, 15); b_recv(2'b00, 4'h2);
    ar_send(32'h100, 4'hF, 8'd15, INCR); r_recv(16, 4'hF, 1'b1);

    // bready held low: bvalid sticks and a new AW is refused
    bus.bready = 1'b0;
    wr_data[0] = 32'hCAFEF00D;
    aw_send(32'h40, 4'hA, 8'd0, INCR); w_send(1, 4'hF, 0);
    bus.awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bhold_bvalid", 32'(bus.bvalid), 32'd1);
      check("bhold_awready", 32'(bus.awready), 32'd0);
      @(negedge clk);
    end
    bus.awvalid = 1'b0;
    bus.bready  = 1'b1;
    b_recv(2'b00, 4'hA);

    // Reset in the middle of an 8-beat write and an 8-beat read
    for (int i = 0; i < 3; i++) wr_data[i] = 32'hC0DE0000 + 32'(i);
    aw_send(32'h200, 4'hB, 8'd7, INCR); w_send(3, 4'hF, -1);
    bus.rready = 1'b0;
    ar_send(32'h100, 4'hC, 8'd7, INCR);
    @(negedge clk);
    check("mid_wready", 32'(bus.wready), 32'd1);
    check("mid_rvalid", 32'(bus.rvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rvalid", 32'(bus.rvalid), 32'd0);
    check("arst_rdata", bus.rdata, 32'd0);
    check("arst_wready", 32'(bus.wready), 32'd0);
    check("arst_bvalid", 32'(bus.bvalid), 32'd0);
    check("arst_awready", 32'(bus.awready), 32'd0);
    check("arst_arready", 32'(bus.arready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.rready = 1'b1;
    @(negedge clk);
    check("rel_awready", 32'(bus.awready), 32'd1);
    check("rel_arready", 32'(bus.arready), 32'd1);
    wr_data[0] = 32'h12345678; wr_data[1] = 32'h9ABCDEF0;
    aw_send(32'h300, 4'hD, 8'd1, INCR); w_send(2, 4'hF, 1); b_recv(2'b00, 4'hD);
    exp_data[0] = 32'h12345678; exp_data[1] = 32'h9ABCDEF0;
    exp_resp[0] = 2'b00; exp_resp[1] = 2'b00;
    ar_send(32'h300, 4'hD, 8'd1, INCR); r_recv(2, 4'hD, 1'b0);
    for (int i = 0; i < 3; i++) begin exp_data[i] = 32'hC0DE0000 + 32'(i); exp_resp[i] = 2'b00; end
    ar_send(32'h200, 4'h1, 8'd2, INCR); r_recv(3, 4'h1, 1'b0);

    // wlast early, and wlast missing on the final beat
    wr_data[0] = 32'h1; wr_data[1] = 32'h2; wr_data[2] = 32'h3;
    aw_send(32'h400, 4'hE, 8'd2, INCR); w_send(3, 4'hF, 0); b_recv(2'b10, 4'hE);
    aw_send(32'h400, 4'hE, 8'd1, INCR); w_send(2, 4'hF, -1); b_recv(2'b10, 4'hE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
